fetch_queue: RTL and testbench

- Decoupling instruction queue between the IF stage and the decode (ID) stage.
- Accepts {PC, instruction} pairs from IF under a valid/ready handshake and buffers up to DEPTH entries.
- Presents the oldest entry to ID.
- Back-pressures IF when full. Discards all contents on a branch-redirect flush.

---
 rtl/fetch_queue.sv | 99 +++++++++
 tb/tb_fetch_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - IF-to-ID decoupling queue of {pc, instr} pairs with flush.
// Optional zero-latency empty-queue forwarding: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter int          PTR_W     = 2,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [15:0]      in_pc,
    input  logic [15:0]      in_instr,
    output logic             in_ready,
    output logic             out_valid,
    output logic [15:0]      out_pc,
    output logic [15:0]      out_instr,
    input  logic             out_ready,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(DEPTH);

    logic [15:0]      r_pc_mem    [DEPTH];
    logic [15:0]      r_instr_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_fifo_valid;
    logic w_push;
    logic w_pop;
`ifdef FETCH_QUEUE_BYPASS_EN
    logic w_bypass;
`endif

    assign w_fifo_valid = (r_count != '0);
    assign in_ready     = (r_count != C_FULL);
    assign count        = r_count;
    assign w_pop        = w_fifo_valid && out_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
    // An empty queue hands the fetch straight to ID; it is stored only if ID stalls.
    assign w_bypass = (r_count == '0) && !flush;
    assign w_push   = in_valid && in_ready && !(w_bypass && out_ready);
`else
    assign w_push   = in_valid && in_ready;
`endif

    always_comb begin
        out_valid = w_fifo_valid;
        out_pc    = 16'h0000;
        out_instr = NOP_INSTR;
        if (w_fifo_valid) begin
            out_pc    = r_pc_mem[r_rd_ptr];
            out_instr = r_instr_mem[r_rd_ptr];
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        if (w_bypass) begin
            out_valid = in_valid;
            out_pc    = in_pc;
            out_instr = in_instr;
        end
`endif
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_pc_mem[r_wr_ptr]    <= in_pc;
            r_instr_mem[r_wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized and directed check of fetch_queue against a queue model.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam logic [15:0] NOP = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_pc = '0;
    logic [15:0] in_instr = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_pc;
    logic [15:0] out_instr;
    logic        out_ready = 1'b0;
    logic [PTR_W:0] count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq[$];

    fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a plain FIFO of {pc, instr} words.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
        end else if (flush) begin
            mq.delete();
        end else begin
            bit do_pop;
            bit do_push;
            do_pop  = (mq.size() > 0) && out_ready;
            do_push = in_valid && (mq.size() < DEPTH);
`ifdef FETCH_QUEUE_BYPASS_EN
            if (mq.size() == 0 && in_valid && out_ready) do_push = 1'b0;
`endif
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({in_pc, in_instr});
        end
    end

    always @(negedge clk) begin
        logic        e_valid;
        logic [15:0] e_pc;
        logic [15:0] e_instr;
        e_valid = (mq.size() > 0);
        e_pc    = e_valid ? mq[0][31:16] : 16'h0000;
        e_instr = e_valid ? mq[0][15:0] : NOP;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (mq.size() == 0 && !flush && !rst) begin
            e_valid = in_valid;
            e_pc    = in_pc;
            e_instr = in_instr;
        end
`endif
        chk("cyc_count", 32'(count), 32'(mq.size()));
        chk("cyc_in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        chk("cyc_out_valid", 32'(out_valid), 32'(e_valid));
        chk("cyc_out_pc", 32'(out_pc), 32'(e_pc));
        chk("cyc_out_instr", 32'(out_instr), 32'(e_instr));
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic push(input logic [15:0] pc);
        in_valid = 1'b1; in_pc = pc; in_instr = pc ^ 16'hA5A5;
    endtask

    initial begin
        #1 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_instr", 32'(out_instr), 0);
        chk("rst_out_pc", 32'(out_pc), 0);
        chk("rst_in_ready", 32'(in_ready), 1);

        // Fill to full, then a fifth offer must be refused.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(16'(i * 4));
            tick();
        end
        chk("fill_count", 32'(count), 4);
        chk("fill_in_ready", 32'(in_ready), 0);
        chk("model_fill_size", 32'(mq.size()), 4);
        push(16'h0010);
        tick();
        chk("fill_reject_count", 32'(count), 4);
        chk("fill_head_pc", 32'(out_pc), 32'h0000);

        // Drain from full in order.
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", 32'(out_pc), 32'(i * 4));
            chk("drain_instr", 32'(out_instr), 32'(16'(i * 4) ^ 16'hA5A5));
            tick();
            if (i == 0) chk("drain_ready_after_pop", 32'(in_ready), 1);
        end
        chk("drain_empty_valid", 32'(out_valid), 0);

        // Streaming through the wrap point: occupancy stays at one.
        for (int i = 0; i < 10; i++) begin
            push(16'h0100 + 16'(i * 4));
            out_ready = 1'b1;
            tick();
`ifndef FETCH_QUEUE_BYPASS_EN
            chk("stream_count", 32'(count), 1);
            chk("stream_pc", 32'(out_pc), 32'(16'h0100 + 16'(i * 4)));
`endif
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drained", 32'(count), 0);

        // Flush with concurrent push and pop.
        idle();
        for (int i = 0; i < 3; i++) begin
            push(16'h0200 + 16'(i * 4));
            tick();
        end
        chk("pre_flush_count", 32'(count), 3);
        flush = 1'b1; push(16'h0040); out_ready = 1'b1;
        tick();
        chk("flush_count", 32'(count), 0);
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_in_ready", 32'(in_ready), 1);
        idle();
        push(16'h0080);
        tick();
        in_valid = 1'b0;
        chk("post_flush_head", 32'(out_pc), 32'h0080);
        chk("post_flush_count", 32'(count), 1);
        flush = 1'b1;
        tick();
        idle();

        // Empty queue with a fetch and ID ready.
        push(16'h0020); out_ready = 1'b1;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("byp_same_cycle_valid", 32'(out_valid), 1);
        chk("byp_same_cycle_pc", 32'(out_pc), 32'h0020);
        tick();
        chk("byp_count", 32'(count), 0);
`else
        chk("nobyp_same_cycle_valid", 32'(out_valid), 0);
        out_ready = 1'b0;
        tick();
        chk("nobyp_next_valid", 32'(out_valid), 1);
        chk("nobyp_next_pc", 32'(out_pc), 32'h0020);
        chk("nobyp_count", 32'(count), 1);
`endif
        idle();
        flush = 1'b1;
        tick();
        idle();

        // Asynchronous reset mid-stream with three entries held.
        for (int i = 0; i < 3; i++) begin
            push(16'h0300 + 16'(i * 4));
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_count", 32'(count), 3);
        rst = 1'b1;
        #1;
        chk("async_rst_count", 32'(count), 0);
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_instr", 32'(out_instr), 0);
        chk("async_rst_ready", 32'(in_ready), 1);
        tick();
        rst = 1'b0;

        // Random traffic checked every cycle by the compare process.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_pc     = 16'($urandom);
            in_instr  = 16'($urandom);
            tick();
        end
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
